// File: rtl/ft245_sync_device_if.sv
// Handshake bundle for the FT245-style synchronous FIFO device: USB-side buffer ports,
// FPGA-side bus strobes and status, and sticky error flags. The data bus stays a plain inout.
interface ft245_sync_device_if;
  logic       usb_rx_wr;
  logic [7:0] usb_rx_data;
  logic       usb_rx_full;
  logic       usb_tx_rd;
  logic [7:0] usb_tx_data;
  logic       usb_tx_empty;
  logic       usb_suspend;
  logic       usb_flush;
  logic       ftdi_rde_n;
  logic       ftdi_rd_n;
  logic       ftdi_oe_n;
  logic       ftdi_wr_n;
  logic       ftdi_siwu;
  logic       ftdi_txe_n;
  logic       ftdi_suspend_n;
  logic       err_underrun;
  logic       err_overrun;
  logic       err_protocol;

  modport slave (
    input  usb_rx_wr, usb_rx_data, usb_tx_rd, usb_suspend,
    input  ftdi_rd_n, ftdi_oe_n, ftdi_wr_n, ftdi_siwu,
    output usb_rx_full, usb_tx_data, usb_tx_empty, usb_flush,
    output ftdi_rde_n, ftdi_txe_n, ftdi_suspend_n,
    output err_underrun, err_overrun, err_protocol
  );

  modport master (
    output usb_rx_wr, usb_rx_data, usb_tx_rd, usb_suspend,
    output ftdi_rd_n, ftdi_oe_n, ftdi_wr_n, ftdi_siwu,
    input  usb_rx_full, usb_tx_data, usb_tx_empty, usb_flush,
    input  ftdi_rde_n, ftdi_txe_n, ftdi_suspend_n,
    input  err_underrun, err_overrun, err_protocol
  );
endinterface

// File: rtl/ft245_sync_device.sv
// FT245 synchronous-FIFO device model: RX/TX circular buffers between a USB-side port and
// an FPGA-facing strobe bus, with registered status flags and sticky error reporting.
module ft245_sync_device #(
  parameter int unsigned RX_AW      = 9,
  parameter int unsigned TX_AW      = 9,
  parameter int unsigned TXE_MARGIN = 1
) (
  input  logic               ftdi_clk,
  input  logic               rst,
  inout  wire  [7:0]         ftdi_data,
  ft245_sync_device_if.slave bus
);

  localparam int unsigned RxDepth = 1 << RX_AW;
  localparam int unsigned TxDepth = 1 << TX_AW;

  typedef enum logic [1:0] {StIdle, StTurn, StRead, StWrite} state_e;

  state_e r_state, w_state_next;

  logic [7:0]     r_rx_mem [RxDepth];
  logic [RX_AW:0] r_rx_wp, r_rx_rp, w_rx_count, w_rx_count_next;
  logic           w_rx_empty, w_rx_full, w_rx_push, w_rx_pop;
  logic [7:0]     w_rx_head;

  logic [7:0]     r_tx_mem [TxDepth];
  logic [TX_AW:0] r_tx_wp, r_tx_rp, w_tx_count, w_tx_count_next, w_tx_free_next;
  logic           w_tx_empty, w_tx_full, w_tx_push, w_tx_pop;

  logic w_rd, w_wr, w_read_phase;
  logic w_underrun, w_overrun, w_protocol;
  logic r_rde_n, r_txe_n, r_suspend_n, r_siwu_prev, r_flush;
  logic r_err_underrun, r_err_overrun, r_err_protocol;

  // Count is the pointer difference; the extra MSB makes a full buffer read as exactly Depth.
  assign w_rx_count = r_rx_wp - r_rx_rp;
  assign w_rx_empty = (w_rx_count == '0);
  assign w_rx_full  = w_rx_count[RX_AW];
  assign w_rx_head  = r_rx_mem[r_rx_rp[RX_AW-1:0]];

  assign w_tx_count = r_tx_wp - r_tx_rp;
  assign w_tx_empty = (w_tx_count == '0);
  assign w_tx_full  = w_tx_count[TX_AW];

  // Suspend masks the FPGA strobes entirely, so blocked accesses raise no errors.
  assign w_rd         = ~bus.ftdi_rd_n & ~bus.usb_suspend;
  assign w_wr         = ~bus.ftdi_wr_n & ~bus.usb_suspend;
  assign w_read_phase = (r_state == StTurn) || (r_state == StRead);

  assign w_rx_pop  = w_rd & ~bus.ftdi_oe_n & w_read_phase & ~w_rx_empty;
  assign w_rx_push = bus.usb_rx_wr & (~w_rx_full | w_rx_pop);
  assign w_tx_pop  = bus.usb_tx_rd & ~w_tx_empty;
  assign w_tx_push = w_wr & bus.ftdi_oe_n & (~w_tx_full | w_tx_pop);

  assign w_underrun = w_rd & w_rx_empty;
  assign w_overrun  = w_wr & bus.ftdi_oe_n & ~w_tx_push;
  assign w_protocol = (w_rd & (r_state == StIdle)) | (w_wr & ~bus.ftdi_oe_n);

  assign w_rx_count_next = w_rx_count + {{RX_AW{1'b0}}, w_rx_push}
                                      - {{RX_AW{1'b0}}, w_rx_pop};
  assign w_tx_count_next = w_tx_count + {{TX_AW{1'b0}}, w_tx_push}
                                      - {{TX_AW{1'b0}}, w_tx_pop};
  assign w_tx_free_next  = {1'b1, {TX_AW{1'b0}}} - w_tx_count_next;

  assign ftdi_data = bus.ftdi_oe_n ? 8'hzz : w_rx_head;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (!bus.ftdi_oe_n)      w_state_next = StTurn;
        else if (!bus.ftdi_wr_n) w_state_next = StWrite;
      end
      StTurn: begin
        if (bus.ftdi_oe_n)       w_state_next = StIdle;
        else if (!bus.ftdi_rd_n) w_state_next = StRead;
      end
      StRead:  if (bus.ftdi_oe_n) w_state_next = StIdle;
      StWrite: if (bus.ftdi_wr_n) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge ftdi_clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wp[RX_AW-1:0]] <= bus.usb_rx_data;
    if (w_tx_push) r_tx_mem[r_tx_wp[TX_AW-1:0]] <= ftdi_data;
  end

  always_ff @(posedge ftdi_clk) begin
    if (rst) begin
      r_state        <= StIdle;
      r_rx_wp        <= '0;
      r_rx_rp        <= '0;
      r_tx_wp        <= '0;
      r_tx_rp        <= '0;
      r_rde_n        <= 1'b1;
      r_txe_n        <= 1'b1;
      r_suspend_n    <= 1'b1;
      r_siwu_prev    <= 1'b1;
      r_flush        <= 1'b0;
      r_err_underrun <= 1'b0;
      r_err_overrun  <= 1'b0;
      r_err_protocol <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
      if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
      r_rde_n     <= (w_rx_count_next == '0) | bus.usb_suspend;
      r_txe_n     <= (32'(w_tx_free_next) <= TXE_MARGIN) | bus.usb_suspend;
      r_suspend_n <= ~bus.usb_suspend;
      r_siwu_prev <= bus.ftdi_siwu;
      r_flush     <= r_siwu_prev & ~bus.ftdi_siwu;
      if (w_underrun) r_err_underrun <= 1'b1;
      if (w_overrun)  r_err_overrun  <= 1'b1;
      if (w_protocol) r_err_protocol <= 1'b1;
    end
  end

  assign bus.usb_rx_full    = w_rx_full;
  assign bus.usb_tx_data    = r_tx_mem[r_tx_rp[TX_AW-1:0]];
  assign bus.usb_tx_empty   = w_tx_empty;
  assign bus.usb_flush      = r_flush;
  assign bus.ftdi_rde_n     = r_rde_n;
  assign bus.ftdi_txe_n     = r_txe_n;
  assign bus.ftdi_suspend_n = r_suspend_n;
  assign bus.err_underrun   = r_err_underrun;
  assign bus.err_overrun    = r_err_overrun;
  assign bus.err_protocol   = r_err_protocol;

endmodule

// File: tb/tb_ft245_sync_device.sv
// Bench for ft245_sync_device: directed scenarios plus randomized traffic, all checked
// against a queue-based model of the two buffers, status flags and error rules.
module tb_ft245_sync_device;
  localparam int RXD    = 512;
  localparam int TXD    = 512;
  localparam int MARGIN = 1;

  logic       ftdi_clk = 1'b0;
  logic       rst;
  logic [7:0] host_data;
  wire  [7:0] ftdi_data;

  ft245_sync_device_if bus ();

  // Host only drives the bus while the device is not output-enabled.
  assign ftdi_data = bus.ftdi_oe_n ? host_data : 8'hzz;

  ft245_sync_device #(.RX_AW(9), .TX_AW(9), .TXE_MARGIN(MARGIN)) dut (
    .ftdi_clk  (ftdi_clk),
    .rst       (rst),
    .ftdi_data (ftdi_data),
    .bus       (bus)
  );

  always #5 ftdi_clk = ~ftdi_clk;

  int checks   = 0;
  int failures = 0;

  byte unsigned rx_q[$];
  byte unsigned tx_q[$];
  bit m_under, m_over, m_proto, m_oe_prev, m_siwu_prev;
  bit e_rde_n, e_txe_n, e_susp_n, e_flush;

  task automatic idle_inputs();
    bus.usb_rx_wr   = 1'b0;
    bus.usb_rx_data = 8'h00;
    bus.usb_tx_rd   = 1'b0;
    bus.usb_suspend = 1'b0;
    bus.ftdi_rd_n   = 1'b1;
    bus.ftdi_oe_n   = 1'b1;
    bus.ftdi_wr_n   = 1'b1;
    bus.ftdi_siwu   = 1'b1;
    host_data       = 8'h00;
  endtask

  // One clock edge: the model applies the rules to the inputs present at the edge.
  task automatic step();
    bit susp, rd, wr, rxpop, rxpush, txpop, txpush;
    @(posedge ftdi_clk);
    if (rst) begin
      rx_q.delete();
      tx_q.delete();
      m_under = 0; m_over = 0; m_proto = 0; m_oe_prev = 0; m_siwu_prev = 1;
      e_rde_n = 1; e_txe_n = 1; e_susp_n = 1; e_flush = 0;
    end else begin
      susp   = bus.usb_suspend;
      rd     = !bus.ftdi_rd_n && !susp;
      wr     = !bus.ftdi_wr_n && !susp;
      rxpop  = rd && !bus.ftdi_oe_n && m_oe_prev && rx_q.size() > 0;
      rxpush = bus.usb_rx_wr && (rx_q.size() < RXD || rxpop);
      txpop  = bus.usb_tx_rd && tx_q.size() > 0;
      txpush = wr && bus.ftdi_oe_n && (tx_q.size() < TXD || txpop);
      if (rd && rx_q.size() == 0) m_under = 1;
      if (wr && bus.ftdi_oe_n && !txpush) m_over = 1;
      if ((rd && !m_oe_prev) || (wr && !bus.ftdi_oe_n)) m_proto = 1;
      if (rxpop)  void'(rx_q.pop_front());
      if (rxpush) rx_q.push_back(bus.usb_rx_data);
      if (txpop)  void'(tx_q.pop_front());
      if (txpush) tx_q.push_back(host_data);
      e_rde_n     = (rx_q.size() == 0) || susp;
      e_txe_n     = ((TXD - tx_q.size()) <= MARGIN) || susp;
      e_susp_n    = !susp;
      e_flush     = m_siwu_prev && !bus.ftdi_siwu;
      m_siwu_prev = bus.ftdi_siwu;
      m_oe_prev   = !bus.ftdi_oe_n;
    end
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({bus.ftdi_rde_n, bus.ftdi_txe_n, bus.ftdi_suspend_n} !== 3'b111) begin
      failures++;
      $display("FAIL reset_flags: got rde/txe/susp=%b%b%b want 111",
               bus.ftdi_rde_n, bus.ftdi_txe_n, bus.ftdi_suspend_n);
    end
    checks++;
    if ({bus.usb_rx_full, bus.usb_tx_empty, bus.usb_flush} !== 3'b010) begin
      failures++;
      $display("FAIL reset_usb: got full/empty/flush=%b%b%b want 010",
               bus.usb_rx_full, bus.usb_tx_empty, bus.usb_flush);
    end
    checks++;
    if ({bus.err_underrun, bus.err_overrun, bus.err_protocol} !== 3'b000) begin
      failures++;
      $display("FAIL reset_errs: got %b%b%b want 000",
               bus.err_underrun, bus.err_overrun, bus.err_protocol);
    end
    rst = 1'b0;
    step();
    checks++;
    if (bus.ftdi_txe_n !== 1'b0 || bus.ftdi_rde_n !== 1'b1) begin
      failures++;
      $display("FAIL post_reset: got txe_n=%b rde_n=%b want 0 1", bus.ftdi_txe_n, bus.ftdi_rde_n);
    end
  endtask

  task automatic test_rx_stream();
    byte unsigned exp_b[3] = '{8'h11, 8'h22, 8'h33};
    do_reset();
    bus.usb_rx_wr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.usb_rx_data = exp_b[i];
      step();
    end
    bus.usb_rx_wr = 1'b0;
    checks++;
    if (bus.ftdi_rde_n !== 1'b0) begin
      failures++;
      $display("FAIL rx_rde_avail: got %b want 0", bus.ftdi_rde_n);
    end
    bus.ftdi_oe_n = 1'b0;
    step();
    bus.ftdi_rd_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ftdi_data !== exp_b[i]) begin
        failures++;
        $display("FAIL rx_stream_%0d: got %02h want %02h", i, ftdi_data, exp_b[i]);
      end
      step();
    end
    checks++;
    if (bus.ftdi_rde_n !== 1'b1) begin
      failures++;
      $display("FAIL rx_rde_drained: got %b want 1", bus.ftdi_rde_n);
    end
    checks++;
    if ({bus.err_underrun, bus.err_overrun, bus.err_protocol} !== 3'b000) begin
      failures++;
      $display("FAIL rx_stream_errs: got %b%b%b want 000",
               bus.err_underrun, bus.err_overrun, bus.err_protocol);
    end
    bus.ftdi_rd_n = 1'b1;
    bus.ftdi_oe_n = 1'b1;
    step();
  endtask

  task automatic test_tx_fill();
    do_reset();
    bus.ftdi_wr_n = 1'b0;
    for (int i = 0; i < 512; i++) begin
      host_data = i[7:0];
      step();
      checks++;
      if (bus.ftdi_txe_n !== e_txe_n) begin
        failures++;
        $display("FAIL tx_fill_txe_%0d: got %b want %b", i, bus.ftdi_txe_n, e_txe_n);
      end
    end
    checks++;
    if (bus.ftdi_txe_n !== 1'b1 || bus.err_overrun !== 1'b0) begin
      failures++;
      $display("FAIL tx_full_state: got txe_n=%b ovr=%b want 1 0",
               bus.ftdi_txe_n, bus.err_overrun);
    end
    host_data = 8'hAA;
    step();
    checks++;
    if (bus.err_overrun !== 1'b1) begin
      failures++;
      $display("FAIL tx_overrun: got %b want 1", bus.err_overrun);
    end
    bus.ftdi_wr_n = 1'b1;
    step();
    bus.usb_tx_rd = 1'b1;
    for (int i = 0; i < 512; i++) begin
      checks++;
      if (bus.usb_tx_empty !== 1'b0 || bus.usb_tx_data !== i[7:0]) begin
        failures++;
        $display("FAIL tx_drain_%0d: got empty=%b data=%02h want 0 %02h",
                 i, bus.usb_tx_empty, bus.usb_tx_data, i[7:0]);
      end
      step();
    end
    bus.usb_tx_rd = 1'b0;
    checks++;
    if (bus.usb_tx_empty !== 1'b1) begin
      failures++;
      $display("FAIL tx_drained: got empty=%b want 1", bus.usb_tx_empty);
    end
  endtask

  task automatic test_rx_wrap();
    do_reset();
    bus.usb_rx_wr = 1'b1;
    for (int i = 0; i < RXD; i++) begin
      bus.usb_rx_data = 8'($urandom);
      step();
    end
    bus.usb_rx_wr = 1'b0;
    checks++;
    if (bus.usb_rx_full !== 1'b1) begin
      failures++;
      $display("FAIL rx_full: got %b want 1", bus.usb_rx_full);
    end
    bus.ftdi_oe_n = 1'b0;
    step();
    bus.ftdi_rd_n = 1'b0;
    bus.usb_rx_wr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.usb_rx_data = 8'($urandom);
      checks++;
      if (ftdi_data !== rx_q[0]) begin
        failures++;
        $display("FAIL rx_wrap_head_%0d: got %02h want %02h", i, ftdi_data, rx_q[0]);
      end
      step();
      checks++;
      if (bus.usb_rx_full !== 1'b1) begin
        failures++;
        $display("FAIL rx_wrap_full_%0d: got %b want 1", i, bus.usb_rx_full);
      end
    end
    bus.usb_rx_wr = 1'b0;
    for (int i = 0; i < RXD; i++) begin
      checks++;
      if (ftdi_data !== rx_q[0]) begin
        failures++;
        $display("FAIL rx_wrap_drain_%0d: got %02h want %02h", i, ftdi_data, rx_q[0]);
      end
      step();
    end
    bus.ftdi_rd_n = 1'b1;
    checks++;
    if (bus.ftdi_rde_n !== 1'b1 || bus.err_underrun !== 1'b0) begin
      failures++;
      $display("FAIL rx_wrap_end: got rde_n=%b und=%b want 1 0", bus.ftdi_rde_n, bus.err_underrun);
    end
    bus.ftdi_oe_n = 1'b1;
    step();
  endtask

  task automatic test_protocol();
    do_reset();
    bus.usb_rx_wr   = 1'b1;
    bus.usb_rx_data = 8'hA5;
    step();
    bus.usb_rx_data = 8'h5A;
    step();
    bus.usb_rx_wr = 1'b0;
    bus.ftdi_rd_n = 1'b0;
    step();
    bus.ftdi_rd_n = 1'b1;
    checks++;
    if (bus.err_protocol !== 1'b1 || bus.err_underrun !== 1'b0) begin
      failures++;
      $display("FAIL proto_rd_idle: got proto=%b und=%b want 1 0",
               bus.err_protocol, bus.err_underrun);
    end
    bus.ftdi_oe_n = 1'b0;
    step();
    checks++;
    if (ftdi_data !== 8'hA5 || bus.ftdi_rde_n !== 1'b0) begin
      failures++;
      $display("FAIL proto_no_pop: got head=%02h rde_n=%b want a5 0", ftdi_data, bus.ftdi_rde_n);
    end
    bus.ftdi_oe_n = 1'b1;
    step();
    do_reset();
    bus.ftdi_oe_n = 1'b0;
    bus.ftdi_wr_n = 1'b0;
    step();
    bus.ftdi_oe_n = 1'b1;
    bus.ftdi_wr_n = 1'b1;
    checks++;
    if (bus.err_protocol !== 1'b1 || bus.usb_tx_empty !== 1'b1) begin
      failures++;
      $display("FAIL proto_wr_oe: got proto=%b tx_empty=%b want 1 1",
               bus.err_protocol, bus.usb_tx_empty);
    end
    step();
  endtask

  task automatic test_flush();
    do_reset();
    step();
    bus.ftdi_siwu = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.ftdi_siwu = 1'b1;
      step();
      checks++;
      if (bus.usb_flush !== (i == 0) || bus.usb_flush !== e_flush) begin
        failures++;
        $display("FAIL flush_%0d: got %b want %b", i, bus.usb_flush, (i == 0));
      end
    end
  endtask

  task automatic test_suspend();
    do_reset();
    bus.usb_rx_wr   = 1'b1;
    bus.usb_rx_data = 8'h3C;
    bus.ftdi_wr_n   = 1'b0;
    host_data       = 8'h7E;
    step();
    bus.usb_rx_data = 8'hC3;
    bus.ftdi_wr_n   = 1'b1;
    step();
    bus.usb_rx_wr   = 1'b0;
    bus.usb_suspend = 1'b1;
    step();
    checks++;
    if ({bus.ftdi_rde_n, bus.ftdi_txe_n, bus.ftdi_suspend_n} !== 3'b110) begin
      failures++;
      $display("FAIL suspend_flags: got rde/txe/susp=%b%b%b want 110",
               bus.ftdi_rde_n, bus.ftdi_txe_n, bus.ftdi_suspend_n);
    end
    bus.ftdi_oe_n = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      bus.ftdi_rd_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      step();
    end
    bus.ftdi_rd_n = 1'b1;
    bus.ftdi_oe_n = 1'b1;
    bus.ftdi_wr_n = 1'b0;
    host_data     = 8'h99;
    step();
    bus.ftdi_wr_n = 1'b1;
    checks++;
    if ({bus.err_underrun, bus.err_overrun, bus.err_protocol} !== 3'b000) begin
      failures++;
      $display("FAIL suspend_errs: got %b%b%b want 000",
               bus.err_underrun, bus.err_overrun, bus.err_protocol);
    end
    bus.usb_suspend = 1'b0;
    step();
    checks++;
    if (bus.ftdi_rde_n !== 1'b0 || bus.ftdi_suspend_n !== 1'b1 || bus.ftdi_txe_n !== e_txe_n) begin
      failures++;
      $display("FAIL resume_flags: got rde_n=%b susp_n=%b txe_n=%b want 0 1 %b",
               bus.ftdi_rde_n, bus.ftdi_suspend_n, bus.ftdi_txe_n, e_txe_n);
    end
    bus.ftdi_oe_n = 1'b0;
    step();
    checks++;
    if (ftdi_data !== 8'h3C) begin
      failures++;
      $display("FAIL suspend_no_pop: got %02h want 3c", ftdi_data);
    end
    bus.ftdi_oe_n = 1'b1;
    checks++;
    if (bus.usb_tx_data !== 8'h7E) begin
      failures++;
      $display("FAIL suspend_tx_head: got %02h want 7e", bus.usb_tx_data);
    end
    bus.usb_tx_rd = 1'b1;
    step();
    bus.usb_tx_rd = 1'b0;
    checks++;
    if (bus.usb_tx_empty !== 1'b1) begin
      failures++;
      $display("FAIL suspend_no_write: got tx_empty=%b want 1", bus.usb_tx_empty);
    end
  endtask

  task automatic test_random();
    int kind;
    int len;
    do_reset();
    for (int ph = 0; ph < 60; ph++) begin
      kind = $urandom_range(0, 2);
      len  = $urandom_range(1, 12);
      for (int c = 0; c <= len; c++) begin
        bus.usb_rx_wr   = 1'($urandom_range(0, 1));
        bus.usb_rx_data = 8'($urandom);
        bus.usb_tx_rd   = ($urandom_range(0, 3) == 0);
        bus.ftdi_oe_n   = 1'b1;
        bus.ftdi_rd_n   = 1'b1;
        bus.ftdi_wr_n   = 1'b1;
        host_data       = 8'($urandom);
        if (c != len && kind == 1) begin
          bus.ftdi_oe_n = 1'b0;
          bus.ftdi_rd_n = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
        if (c != len && kind == 2) bus.ftdi_wr_n = 1'($urandom_range(0, 1));
        #1;
        if (!bus.ftdi_oe_n && rx_q.size() > 0) begin
          checks++;
          if (ftdi_data !== rx_q[0]) begin
            failures++;
            $display("FAIL rand_rx_head: got %02h want %02h", ftdi_data, rx_q[0]);
          end
        end
        if (tx_q.size() > 0) begin
          checks++;
          if (bus.usb_tx_data !== tx_q[0]) begin
            failures++;
            $display("FAIL rand_tx_head: got %02h want %02h", bus.usb_tx_data, tx_q[0]);
          end
        end
        step();
        checks++;
        if (bus.ftdi_rde_n !== e_rde_n || bus.ftdi_txe_n !== e_txe_n ||
            bus.usb_rx_full !== (rx_q.size() == RXD) || bus.usb_tx_empty !== (tx_q.size() == 0)) begin
          failures++;
          $display("FAIL rand_status: got rde/txe/full/empty=%b%b%b%b want %b%b%b%b",
                   bus.ftdi_rde_n, bus.ftdi_txe_n, bus.usb_rx_full, bus.usb_tx_empty,
                   e_rde_n, e_txe_n, (rx_q.size() == RXD), (tx_q.size() == 0));
        end
        checks++;
        if ({bus.err_underrun, bus.err_overrun, bus.err_protocol} !== {m_under, m_over, m_proto}) begin
          failures++;
          $display("FAIL rand_errs: got %b%b%b want %b%b%b", bus.err_underrun,
                   bus.err_overrun, bus.err_protocol, m_under, m_over, m_proto);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_rx_stream();
    test_tx_fill();
    test_rx_wrap();
    test_protocol();
    test_flush();
    test_suspend();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
